// File: rtl/serial_subtractor.sv
//==============================================================================
// Module      : serial_subtractor
// Description : Bit-serial N-bit subtractor. It computes a - b - bin one bit
//               per clock, LSB first, using a single full-subtractor cell and
//               a borrow flop. Operands are captured on an accepted start. A
//               one-cycle done pulse marks diff/bout/ov valid. The result is
//               held until the next operation completes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ov
);

    // Bit counter only needs to reach N-1, so ceil(log2(N)) bits suffice.
    localparam int C_CW = $clog2(N);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_a_sr;
    logic [N-1:0]    r_b_sr;
    logic [N-1:0]    r_res;
    logic            r_br;
    logic [C_CW-1:0] r_cnt;
    logic            r_a_msb;
    logic            r_b_msb;

    logic            w_ai;
    logic            w_bi;
    logic            w_d;
    logic            w_br_next;
    logic [N-1:0]    w_res_next;
    logic            w_ov;

    // Full-subtractor cell operating on the current LSBs and the stored borrow.
    // The new difference bit enters the result register at the MSB, so after
    // N shifts bit 0 of the operands has landed in bit 0 of the result.
    // On the final step w_d is the result MSB, which feeds the overflow term.
    always_comb begin
        w_ai       = r_a_sr[0];
        w_bi       = r_b_sr[0];
        w_d        = w_ai ^ w_bi ^ r_br;
        w_br_next  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
        w_res_next = {w_d, r_res[N-1:1]};
        w_ov       = (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
    end

    // Control FSM, operand/result shift registers and the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            ov      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_a_msb <= a[N-1];
                        r_b_msb <= b[N-1];
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // A start seen here is deliberately ignored (no queuing).
                    r_a_sr <= {1'b0, r_a_sr[N-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[N-1:1]};
                    r_br   <= w_br_next;
                    r_res  <= w_res_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        // Publish the result only now; the partial result stays internal.
                        diff    <= w_res_next;
                        bout    <= w_br_next;
                        ov      <= w_ov;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
//==============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (N=8). Directed
//               cases plus a randomized sweep are checked against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;
    logic         ov;

    int n_tests;
    int n_fail;

    // Last result the DUT is expected to be holding.
    logic [N-1:0] exp_diff;
    logic         exp_bout;
    logic         exp_ov;

    serial_subtractor #(.N(N)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ov    (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: plain unsigned and signed arithmetic.
    task automatic model(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tbin,
                         output logic [N-1:0] rd, output logic rb, output logic ro);
        int ua, ub, u, sa, sb, s;
        ua = int'(ta);
        ub = int'(tb_v);
        u  = ua - ub - int'(tbin);
        rd = N'(u);
        rb = (u < 0);
        sa = ua - ((ua >= (1 << (N-1))) ? (1 << N) : 0);
        sb = ub - ((ub >= (1 << (N-1))) ? (1 << N) : 0);
        s  = sa - sb - int'(tbin);
        ro = (s < -(1 << (N-1))) || (s > (1 << (N-1)) - 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("idle_done", done, 1'b0);
            chk("idle_busy", busy, 1'b0);
            chk("idle_diff", diff, exp_diff);
            chk("idle_bout", bout, exp_bout);
            chk("idle_ov",   ov,   exp_ov);
        end
    endtask

    // Run one operation. restart_at >= 0 re-pulses start with new operands
    // in that SHIFT cycle; the result must still match the captured operands.
    task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tbin,
                         input int restart_at);
        logic [N-1:0] md;
        logic         mb, mo;
        int           cyc, busy_cnt;
        bit           seen;
        model(ta, tb_v, tbin, md, mb, mo);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0; busy_cnt = 0; seen = 0;
        while (!seen && cyc < 40) begin
            if (done) begin
                seen = 1;
            end else begin
                if (busy) busy_cnt++;
                chk("shift_diff", diff, exp_diff);
                chk("shift_bout", bout, exp_bout);
                chk("shift_ov",   ov,   exp_ov);
                if (cyc == restart_at) begin
                    start = 1'b1; a = 8'hAA; b = 8'h55; bin = ~tbin;
                end else begin
                    start = 1'b0;
                end
                step();
                cyc++;
            end
        end
        start = 1'b0;
        chk("done_seen", seen, 1'b1);
        chk("latency",   cyc, N);
        chk("busy_cycles", busy_cnt, N);
        chk("done_busy", busy, 1'b0);
        chk("diff", diff, md);
        chk("bout", bout, mb);
        chk("ov",   ov,   mo);
        exp_diff = md; exp_bout = mb; exp_ov = mo;
        step();
        chk("done_width", done, 1'b0);
        chk("post_busy",  busy, 1'b0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        exp_diff = '0; exp_bout = 1'b0; exp_ov = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_bout", bout, 1'b0);
        chk("rst_ov",   ov,   1'b0);
        rst = 1'b0;
        idle(2);

        // Directed cases with hand-derived expectations.
        do_op(8'h35, 8'h12, 1'b0, -1);
        chk("d1_diff", diff, 8'h23);
        chk("d1_bout", bout, 1'b0);
        idle(1);
        do_op(8'h00, 8'h01, 1'b0, -1);
        chk("d2_diff", diff, 8'hFF);
        chk("d2_bout", bout, 1'b1);
        do_op(8'h10, 8'h10, 1'b1, -1);
        chk("d3_diff", diff, 8'hFF);
        chk("d3_bout", bout, 1'b1);
        do_op(8'h10, 8'h10, 1'b0, -1);
        chk("eq_diff", diff, 8'h00);
        chk("eq_bout", bout, 1'b0);
        do_op(8'h00, 8'hFF, 1'b1, -1);
        chk("wrap_diff", diff, 8'h00);
        chk("wrap_bout", bout, 1'b1);
        do_op(8'h80, 8'h01, 1'b0, -1);
        chk("ov1_diff", diff, 8'h7F);
        chk("ov1_ov",   ov,   1'b1);
        do_op(8'h7F, 8'hFF, 1'b0, -1);
        chk("ov2_diff", diff, 8'h80);
        chk("ov2_bout", bout, 1'b1);
        chk("ov2_ov",   ov,   1'b1);

        // Restart attempt with changed operands mid-operation.
        do_op(8'h35, 8'h12, 1'b0, 3);
        chk("rs_diff", diff, 8'h23);
        idle(5);

        // Asynchronous reset during SHIFT cycle 4.
        begin
            bit got_done;
            a = 8'h5A; b = 8'h21; bin = 1'b0; start = 1'b1;
            step();
            start = 1'b0;
            repeat (4) step();
            chk("pre_rst_busy", busy, 1'b1);
            #2;
            rst = 1'b1;
            #1;
            chk("arst_busy", busy, 1'b0);
            chk("arst_done", done, 1'b0);
            chk("arst_diff", diff, 8'h00);
            chk("arst_bout", bout, 1'b0);
            chk("arst_ov",   ov,   1'b0);
            exp_diff = '0; exp_bout = 1'b0; exp_ov = 1'b0;
            step();
            rst = 1'b0;
            got_done = 0;
            for (int i = 0; i < N + 4; i++) begin
                step();
                if (done) got_done = 1;
            end
            chk("arst_no_done", got_done, 1'b0);
            chk("arst_hold_diff", diff, 8'h00);
        end
        do_op(8'hC8, 8'h64, 1'b0, -1);
        chk("post_rst_diff", diff, 8'h64);
        chk("post_rst_bout", bout, 1'b0);
        chk("post_rst_ov",   ov,   1'b1);

        // Random sweep with random idle gaps.
        for (int k = 0; k < 1000; k++) begin
            logic [N-1:0] ra, rb;
            logic         rbin;
            ra   = N'($urandom);
            rb   = N'($urandom);
            rbin = 1'($urandom);
            do_op(ra, rb, rbin, -1);
            idle(int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
